// File: rtl/ape_mc_dec.sv
// Multi-channel APE decryptor: per-channel chaining state, one word per cycle, output FIFO.
// Optional macro APE_TAG_CHECK_EN enables last-word tag comparison and tag-mismatch errors.
module ape_mc_dec #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 8,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              key_load_i,
  input  logic [CH_W-1:0]   key_ch_i,
  input  logic [63:0]       key_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CH_W-1:0]   in_ch_i,
  input  logic [33:0]       in_ct_i,
  input  logic              in_last_i,
  input  logic [15:0]       tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CH_W-1:0]   out_ch_o,
  output logic [33:0]       out_pt_o,
  output logic              out_last_o,
  output logic              out_tag_ok_o,
  output logic [NUM_CH-1:0] err_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);
  localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [33:0]     pt;
    logic            last;
    logic            tag_ok;
  } ent_t;

  localparam ent_t ENT_RST = '{ch: '0, pt: '0, last: 1'b0, tag_ok: 1'b1};

  function automatic logic [49:0] ape_pe(input logic [49:0] x);
    logic [49:0] s;
    s = x;
    for (int r = 0; r < 4; r++) begin
      s = s ^ {s[40:0], 9'b0};
      s = {s[30:0], s[49:31]};
      s = s ^ {23'b0, s[49:23]};
      s = s ^ {44'b0, 6'(r + 1)};
    end
    return s;
  endfunction

  logic [33:0]       p_q [NUM_CH];
  logic [33:0]       p_d [NUM_CH];
  logic [15:0]       v_q [NUM_CH];
  logic [15:0]       v_d [NUM_CH];
  logic [NUM_CH-1:0] keyed_q, keyed_d, err_q, err_d;
  ent_t              mem_q [DEPTH];
  ent_t              mem_d [DEPTH];
  logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]       cnt_q, cnt_d, cnt_after_pop;
  ent_t              head_q, head_d;

  logic        full, acc, ch_ok, key_ok, push, pop, tag_ok;
  logic [49:0] s;
  logic [15:0] v_new;
  ent_t        push_ent;
  logic        unused_in;

  assign unused_in = ^{key_i[63:50], tag_i};

  assign full       = (cnt_q == DEPTH_L);
  assign in_ready_o = !full && !key_load_i;
  assign acc        = in_valid_i && in_ready_o;
  assign ch_ok      = ({1'b0, in_ch_i} < NUM_CH_L);
  assign key_ok     = ({1'b0, key_ch_i} < NUM_CH_L);
  assign push       = acc && ch_ok && keyed_q[in_ch_i];
  assign pop        = (cnt_q != '0) && out_ready_i;

  assign s     = ape_pe({p_q[in_ch_i], v_q[in_ch_i]});
  assign v_new = s[15:0] ^ in_ct_i[15:0];

`ifdef APE_TAG_CHECK_EN
  assign tag_ok = !in_last_i || (v_new == tag_i);
`else
  assign tag_ok = 1'b1;
`endif

  assign push_ent = '{ch: in_ch_i, pt: in_ct_i ^ s[49:16], last: in_last_i, tag_ok: tag_ok};

  always_comb begin
    p_d     = p_q;
    v_d     = v_q;
    keyed_d = keyed_q;
    err_d   = err_q;
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    head_d  = head_q;
    if (key_load_i && key_ok) begin
      p_d[key_ch_i]     = key_i[49:16];
      v_d[key_ch_i]     = key_i[15:0];
      keyed_d[key_ch_i] = 1'b1;
      err_d[key_ch_i]   = 1'b0;
    end
    if (acc && ch_ok && !keyed_q[in_ch_i]) begin
      err_d[in_ch_i] = 1'b1;
    end
    if (push) begin
      p_d[in_ch_i] = in_ct_i;
      v_d[in_ch_i] = v_new;
      if (!tag_ok) begin
        err_d[in_ch_i] = 1'b1;
      end
      mem_d[wr_q] = push_ent;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) begin
      rd_d = rd_q + AW'(1);
    end
    cnt_after_pop = cnt_q - (AW + 1)'(pop);
    cnt_d         = cnt_after_pop + (AW + 1)'(push);
    // Head register holds its last value once the FIFO drains.
    if (cnt_d != '0) begin
      head_d = (cnt_after_pop == '0) ? push_ent : mem_q[rd_d];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        p_q[i] <= '0;
        v_q[i] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= ENT_RST;
      end
      keyed_q <= '0;
      err_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      head_q  <= ENT_RST;
    end else begin
      p_q     <= p_d;
      v_q     <= v_d;
      mem_q   <= mem_d;
      keyed_q <= keyed_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
    end
  end

  assign out_valid_o  = (cnt_q != '0);
  assign out_ch_o     = head_q.ch;
  assign out_pt_o     = head_q.pt;
  assign out_last_o   = head_q.last;
  assign out_tag_ok_o = head_q.tag_ok;
  assign err_o        = err_q;
endmodule

// File: doc/ape_mc_dec.md
# ape_mc_dec

Multi-channel, parametrised successor to the single-stream APE instruction decryptor. It holds per-channel chaining state (previous ciphertext P, capacity V) and decrypts one ciphertext word per cycle using the 50-bit `ape_pe` permutation. Plaintext, channel id and the tag verdict go into an output FIFO. It sits between the encrypted instruction fetch path and the decode stage; each channel serves one independent instruction stream.

## Interface
- `NUM_CH`, 4: number of independent channels; CH_W = max(1, $clog2(NUM_CH)).
- `DEPTH`, 8: output FIFO depth, power of two, ≥ 2.
- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_i` in 1: reset, asynchronous and active-high.
- `key_load_i` in 1: load key into channel `key_ch_i`.
- `key_ch_i` in CH_W: channel to key.
- `key_i` in 64: key; only bits [49:0] are used.
- `in_valid_i` in 1: ciphertext word valid.
- `in_ready_o` out 1: word is accepted when valid && ready.
- `in_ch_i` in CH_W: channel of the word.
- `in_ct_i` in 34: ciphertext word.
- `in_last_i` in 1: last word of the message.
- `tag_i` in 16: expected tag; sampled with the last word.
- `out_valid_o` out 1: FIFO head valid.
- `out_ready_i` in 1: pops the head when valid && ready.
- `out_ch_o` out CH_W, `out_pt_o` out 34, `out_last_o` out 1, `out_tag_ok_o` out 1: FIFO head fields.
- `err_o` out NUM_CH: sticky per-channel error.

## Operation
- Per-channel registers: P_c (34), V_c (16), keyed_c (1).
- Key load: {P_c, V_c} <= key_i[49:0]. keyed_c <= 1 and err_o[c] <= 0.
- Accept on channel c:
  - S = ape_pe({P_c, V_c}).
  - pt = in_ct_i ^ S[49:16].
  - P_c <= in_ct_i.
  - V_c <= S[15:0] ^ in_ct_i[15:0].
  - Push {c, pt, last, tag_ok} into the FIFO.
- Last word: tag_ok = (S[15:0] ^ in_ct_i[15:0]) == tag_i. On mismatch, err_o[c] <= 1. For non-last words tag_ok = 1.
- Unkeyed channel (keyed_c = 0): the word is accepted and dropped. Nothing is pushed, err_o[c] <= 1, and no state changes.
- Index wrap: in_ch_i ≥ NUM_CH is treated like an unkeyed channel, except no err bit is set and the word is silently dropped.
- `in_ready_o` = !full && !key_load_i. A key load in the same cycle as valid input blocks the input.
- Full FIFO: `in_ready_o` is low. There is no pass-through, even if a pop happens in the same cycle.
- Empty FIFO: `out_valid_o` is low and the head fields hold their last values.
- Simultaneous push and pop when not full: the count is unchanged and both succeed.
- Back-to-back words on the same channel: the state update is visible to the next cycle's word. There is no stall.

## Timing
- Reset values:
  - `in_ready_o` = 1 and `out_valid_o` = 0.
  - `out_ch_o`, `out_pt_o`, `out_last_o` = 0. `out_tag_ok_o` = 1.
  - `err_o` = 0. All P/V = 0, keyed = 0, FIFO empty.
- Latency: a word accepted at edge N appears at the head after edge N (valid in cycle N+1) if the FIFO was empty.
- Throughput: 1 word/cycle sustained while `out_ready_i` = 1.
- Key load takes effect at the edge. A word on that channel may be accepted from the next cycle.
- Reset asserted mid-stream clears everything asynchronously. All channels must be re-keyed.

## Configuration
- `APE_TAG_CHECK_EN` defined: tag comparison, `out_tag_ok_o` and tag-mismatch errors behave as described.
- Not defined: `tag_i` is ignored, `out_tag_ok_o` is constant 1, and `err_o` reports only unkeyed-channel accesses.

## Test plan
- Reset, then key ch0 with 64'h1234567890ABCDEF -> internal P0 = 34'h0567890AB, V0 = 16'hCDEF. Send ct 34'hf37b80e1 -> out_pt = 34'hf37b80e1 ^ ape_pe(50'h0567890ABCDEF)[49:16], out_valid in the next cycle.
- Stream the 9-word sequence 34'hf37b80e1, 34'h5a000003, …, 34'h737ba0e0 on ch0 with last on word 9 and the matching model tag -> 9 outputs in order, out_last only on the 9th, tag_ok = 1, err_o = 0.
- Same stream with tag_i = 16'haded XOR 1 vs the model -> 9th output has tag_ok = 0 and err_o[0] = 1 (with `APE_TAG_CHECK_EN`). Without the macro -> tag_ok = 1 and err_o = 0.
- Interleave ch0/ch2 words with out_ready_i = 0 -> in_ready drops after DEPTH = 8 pushes. Release -> outputs match independent per-channel models; a push and pop in the same cycle keeps the count unchanged.
- Word on unkeyed ch3 -> nothing output and err_o[3] = 1. Key ch3 -> err_o[3] clears. key_load_i with in_valid_i -> in_ready_o = 0 that cycle.
- Assert rst_i mid-stream with 5 entries queued -> out_valid drops immediately. Next word on ch0 is dropped with err_o[0] = 1.
